// File: rtl/vga_pkg.sv
// Shared types, default 1024x768 timing constants and the colour-bar table.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } pattern_mode_t;

    localparam int DEF_H_VISIBLE = 1024;
    localparam int DEF_H_FRONT   = 24;
    localparam int DEF_H_SYNC    = 136;
    localparam int DEF_H_BACK    = 160;
    localparam int DEF_V_VISIBLE = 768;
    localparam int DEF_V_FRONT   = 3;
    localparam int DEF_V_SYNC    = 6;
    localparam int DEF_V_BACK    = 29;

    localparam int BAR_COUNT = 8;

    // Bar colour table, returned as {r,g,b} on/off bits, left to right.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111; // white
            3'd1:    rgb = 3'b110; // yellow
            3'd2:    rgb = 3'b011; // cyan
            3'd3:    rgb = 3'b010; // green
            3'd4:    rgb = 3'b101; // magenta
            3'd5:    rgb = 3'b100; // red
            3'd6:    rgb = 3'b001; // blue
            3'd7:    rgb = 3'b000; // black
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical raster counters and the decode of visible and sync regions.
// Region order on both axes is visible, front porch, sync, back porch.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pixel_enable,
    output logic [$clog2(H_VISIBLE)-1:0]  px,
    output logic [$clog2(V_VISIBLE)-1:0]  py,
    output logic                          visible,
    output logic                          h_sync_region,
    output logic                          v_sync_region,
    output logic                          at_origin
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);
    localparam int PX_W    = $clog2(H_VISIBLE);
    localparam int PY_W    = $clog2(V_VISIBLE);

    localparam logic [HC_W-1:0] H_ZERO    = HC_W'(0);
    localparam logic [HC_W-1:0] H_ONE     = HC_W'(1);
    localparam logic [HC_W-1:0] H_LAST    = HC_W'(H_TOTAL - 1);
    localparam logic [HC_W-1:0] H_VIS_END = HC_W'(H_VISIBLE);
    localparam logic [HC_W-1:0] HS_FIRST  = HC_W'(H_VISIBLE + H_FRONT);
    localparam logic [HC_W-1:0] HS_LAST   = HC_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);

    localparam logic [VC_W-1:0] V_ZERO    = VC_W'(0);
    localparam logic [VC_W-1:0] V_ONE     = VC_W'(1);
    localparam logic [VC_W-1:0] V_LAST    = VC_W'(V_TOTAL - 1);
    localparam logic [VC_W-1:0] V_VIS_END = VC_W'(V_VISIBLE);
    localparam logic [VC_W-1:0] VS_FIRST  = VC_W'(V_VISIBLE + V_FRONT);
    localparam logic [VC_W-1:0] VS_LAST   = VC_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [HC_W-1:0] h_count_r;
    logic [VC_W-1:0] v_count_r;

    // Raster position: advance one pixel per strobe, step the line on horizontal wrap.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_count_r <= H_ZERO;
            v_count_r <= V_ZERO;
        end else if (pixel_enable) begin
            if (h_count_r == H_LAST) begin
                h_count_r <= H_ZERO;
                if (v_count_r == V_LAST) begin
                    v_count_r <= V_ZERO;
                end else begin
                    v_count_r <= v_count_r + V_ONE;
                end
            end else begin
                h_count_r <= h_count_r + H_ONE;
            end
        end
    end

    // Region decode; vertical sync depends on the line number only, so it spans whole lines.
    always_comb begin
        visible       = (h_count_r < H_VIS_END) && (v_count_r < V_VIS_END);
        h_sync_region = (h_count_r >= HS_FIRST) && (h_count_r <= HS_LAST);
        v_sync_region = (v_count_r >= VS_FIRST) && (v_count_r <= VS_LAST);
        at_origin     = (h_count_r == H_ZERO) && (v_count_r == V_ZERO);
        if (visible) begin
            px = h_count_r[PX_W-1:0];
            py = v_count_r[PY_W-1:0];
        end else begin
            px = {PX_W{1'b0}};
            py = {PY_W{1'b0}};
        end
    end

endmodule

// File: rtl/vga_pattern_generator.sv
// VGA test-pattern generator: bars, checkerboard, gradient or solid colour,
// with every output registered one clock behind the raster counters.
module vga_pattern_generator
    import vga_pkg::*;
#(
    parameter int H_VISIBLE     = DEF_H_VISIBLE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_VISIBLE     = DEF_V_VISIBLE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter bit H_SYNC_ACTIVE = 1'b0,
    parameter bit V_SYNC_ACTIVE = 1'b0,
    parameter int COLOR_BITS    = 4,
    parameter int CHECKER_SHIFT = 5
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          pixel_enable,
    input  logic [1:0]                    pattern_mode,
    input  logic [2:0]                    solid_color,
    output logic [COLOR_BITS-1:0]         red,
    output logic [COLOR_BITS-1:0]         green,
    output logic [COLOR_BITS-1:0]         blue,
    output logic                          horizontal_sync,
    output logic                          vertical_sync,
    output logic                          display_enable,
    output logic [$clog2(H_VISIBLE)-1:0]  pixel_x,
    output logic [$clog2(V_VISIBLE)-1:0]  pixel_y,
    output logic                          frame_start
);

    localparam int PX_W      = $clog2(H_VISIBLE);
    localparam int PY_W      = $clog2(V_VISIBLE);
    localparam int BAR_WIDTH = (H_VISIBLE >= BAR_COUNT) ? (H_VISIBLE / BAR_COUNT) : 1;

    localparam logic [COLOR_BITS-1:0] FULL = {COLOR_BITS{1'b1}};
    localparam logic [COLOR_BITS-1:0] ZERO = {COLOR_BITS{1'b0}};

    logic [PX_W-1:0]       px_s;
    logic [PY_W-1:0]       py_s;
    logic                  visible_s;
    logic                  hs_region_s;
    logic                  vs_region_s;
    logic                  origin_s;

    pattern_mode_t         mode_r;
    logic [2:0]            solid_r;
    pattern_mode_t         mode_s;
    logic [2:0]            solid_s;

    int                    bar_q_s;
    logic [2:0]            bar_idx_s;
    logic [2:0]            bar_rgb_s;
    logic [COLOR_BITS-1:0] red_s;
    logic [COLOR_BITS-1:0] green_s;
    logic [COLOR_BITS-1:0] blue_s;

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) u_timing (
        .clock         (clock),
        .reset_n       (reset_n),
        .pixel_enable  (pixel_enable),
        .px            (px_s),
        .py            (py_s),
        .visible       (visible_s),
        .h_sync_region (hs_region_s),
        .v_sync_region (vs_region_s),
        .at_origin     (origin_s)
    );

    // Mode in effect for this pixel: the origin pixel already uses the inputs it latches.
    always_comb begin
        if (origin_s) begin
            mode_s  = pattern_mode_t'(pattern_mode);
            solid_s = solid_color;
        end else begin
            mode_s  = mode_r;
            solid_s = solid_r;
        end
    end

    // Bar index: column divided by bar width, saturated at the last bar.
    always_comb begin
        bar_q_s = int'(px_s) / BAR_WIDTH;
        if (bar_q_s > BAR_COUNT - 1) begin
            bar_idx_s = 3'(BAR_COUNT - 1);
        end else begin
            bar_idx_s = 3'(bar_q_s);
        end
        bar_rgb_s = bar_rgb(bar_idx_s);
    end

    // Pixel colour for the current raster position; black outside the visible area.
    always_comb begin
        red_s   = ZERO;
        green_s = ZERO;
        blue_s  = ZERO;
        if (visible_s) begin
            case (mode_s)
                MODE_BARS: begin
                    red_s   = bar_rgb_s[2] ? FULL : ZERO;
                    green_s = bar_rgb_s[1] ? FULL : ZERO;
                    blue_s  = bar_rgb_s[0] ? FULL : ZERO;
                end
                MODE_CHECKER: begin
                    if (px_s[CHECKER_SHIFT] ^ py_s[CHECKER_SHIFT]) begin
                        red_s   = FULL;
                        green_s = FULL;
                        blue_s  = FULL;
                    end else begin
                        red_s   = ZERO;
                        green_s = ZERO;
                        blue_s  = ZERO;
                    end
                end
                MODE_GRADIENT: begin
                    red_s   = px_s[PX_W-1 -: COLOR_BITS];
                    green_s = px_s[PX_W-1 -: COLOR_BITS];
                    blue_s  = px_s[PX_W-1 -: COLOR_BITS];
                end
                MODE_SOLID: begin
                    red_s   = solid_s[2] ? FULL : ZERO;
                    green_s = solid_s[1] ? FULL : ZERO;
                    blue_s  = solid_s[0] ? FULL : ZERO;
                end
                default: begin
                    red_s   = ZERO;
                    green_s = ZERO;
                    blue_s  = ZERO;
                end
            endcase
        end else begin
            red_s   = ZERO;
            green_s = ZERO;
            blue_s  = ZERO;
        end
    end

    // Output and mode registers; everything holds while the pixel strobe is low.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            red             <= ZERO;
            green           <= ZERO;
            blue            <= ZERO;
            horizontal_sync <= ~H_SYNC_ACTIVE;
            vertical_sync   <= ~V_SYNC_ACTIVE;
            display_enable  <= 1'b0;
            pixel_x         <= {PX_W{1'b0}};
            pixel_y         <= {PY_W{1'b0}};
            frame_start     <= 1'b0;
            mode_r          <= MODE_BARS;
            solid_r         <= 3'b000;
        end else if (pixel_enable) begin
            red             <= red_s;
            green           <= green_s;
            blue            <= blue_s;
            horizontal_sync <= hs_region_s ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
            vertical_sync   <= vs_region_s ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
            display_enable  <= visible_s;
            pixel_x         <= px_s;
            pixel_y         <= py_s;
            frame_start     <= origin_s;
            mode_r          <= mode_s;
            solid_r         <= solid_s;
        end
    end

endmodule

// File: tb/tb_vga_pattern_generator.sv
// Bench for vga_pattern_generator: a reduced-timing instance checked every clock
// against a scoreboard model plus a table of hand-derived pixels, and a
// default-timing instance checked over its first line.
module tb_vga_pattern_generator;

    localparam int HV = 32, HF = 2, HS = 4, HB = 6, HT = 44;
    localparam int VV = 24, VF = 1, VS = 2, VB = 3, VT = 30;
    localparam int CS = 2;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BARS = 24'b111_110_011_010_101_100_001_000;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       de;
        logic       fs;
        logic [4:0] px;
        logic [4:0] py;
    } out_t;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] solid;
        int         x;
        int         y;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       pixel_enable;
    logic [1:0] pattern_mode;
    logic [2:0] solid_color;

    logic [3:0] red, green, blue;
    logic       horizontal_sync, vertical_sync, display_enable, frame_start;
    logic [4:0] pixel_x, pixel_y;

    logic [3:0] f_red, f_green, f_blue;
    logic       f_hs, f_vs, f_de, f_fs;
    logic [9:0] f_px, f_py;

    int         checks = 0;
    int         failures = 0;
    int         mh, mv;
    logic [1:0] mmode;
    logic [2:0] msolid;
    out_t       exp_now;
    out_t       sb_q[$];
    vec_t       vecs[14];

    always #5 clock = ~clock;

    vga_pattern_generator #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_ACTIVE(1'b0), .V_SYNC_ACTIVE(1'b0),
        .COLOR_BITS(4), .CHECKER_SHIFT(CS)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pixel_enable(pixel_enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .red(red), .green(green), .blue(blue),
        .horizontal_sync(horizontal_sync), .vertical_sync(vertical_sync),
        .display_enable(display_enable), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start)
    );

    vga_pattern_generator dut_full (
        .clock(clock), .reset_n(reset_n), .pixel_enable(pixel_enable),
        .pattern_mode(pattern_mode), .solid_color(solid_color),
        .red(f_red), .green(f_green), .blue(f_blue),
        .horizontal_sync(f_hs), .vertical_sync(f_vs),
        .display_enable(f_de), .pixel_x(f_px), .pixel_y(f_py),
        .frame_start(f_fs)
    );

    function automatic out_t reset_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    function automatic out_t model_pixel(int h, int v, logic [1:0] md, logic [2:0] sc);
        out_t o;
        logic [4:0] x, y;
        logic [2:0] rgb;
        int bar;
        o = '0;
        rgb = 3'b000;
        o.hs = (h >= HV + HF && h < HV + HF + HS) ? 1'b0 : 1'b1;
        o.vs = (v >= VV + VF && v < VV + VF + VS) ? 1'b0 : 1'b1;
        o.fs = (h == 0 && v == 0);
        if (h < HV && v < VV) begin
            x = 5'(h);
            y = 5'(v);
            o.de = 1'b1;
            o.px = x;
            o.py = y;
            if (md == 2'd2) begin
                o.r = x[4:1];
                o.g = x[4:1];
                o.b = x[4:1];
            end else begin
                if (md == 2'd0) begin
                    bar = h / (HV / 8);
                    if (bar > 7) bar = 7;
                    rgb = BARS[3 * (7 - bar) +: 3];
                end else if (md == 2'd1) begin
                    rgb = (x[CS] ^ y[CS]) ? 3'b111 : 3'b000;
                end else begin
                    rgb = sc;
                end
                o.r = {4{rgb[2]}};
                o.g = {4{rgb[1]}};
                o.b = {4{rgb[0]}};
            end
        end
        return o;
    endfunction

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, expv, $time);
        end
    endtask

    // One clock: predict into the scoreboard, clock the DUT, compare its outputs.
    task automatic tick();
        out_t e;
        out_t got;
        if (!reset_n) begin
            e = reset_out();
            mh = 0; mv = 0; mmode = 2'd0; msolid = 3'd0;
        end else if (pixel_enable) begin
            if (mh == 0 && mv == 0) begin
                mmode = pattern_mode;
                msolid = solid_color;
            end
            e = model_pixel(mh, mv, mmode, msolid);
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh++;
            end
        end else begin
            e = exp_now;
        end
        exp_now = e;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = '{red, green, blue, horizontal_sync, vertical_sync, display_enable,
                frame_start, pixel_x, pixel_y};
        e = sb_q.pop_front();
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL scoreboard t=%0t got=%h exp=%h", $time, got, e);
        end
    endtask

    initial begin
        int hs_first, hs_last, hs_cnt, de_cnt;
        int fs_cnt, vs_first, vs_last, vs_cnt;
        int en_cnt, rises;
        logic hit, prev_fs, pe_edge;

        vecs[0]  = '{2'd0, 3'd0,  3,  0, 4'hF, 4'hF, 4'hF};
        vecs[1]  = '{2'd0, 3'd0,  4,  0, 4'hF, 4'hF, 4'h0};
        vecs[2]  = '{2'd0, 3'd0,  8,  1, 4'h0, 4'hF, 4'hF};
        vecs[3]  = '{2'd0, 3'd0, 20,  2, 4'hF, 4'h0, 4'h0};
        vecs[4]  = '{2'd0, 3'd0, 31,  2, 4'h0, 4'h0, 4'h0};
        vecs[5]  = '{2'd1, 3'd0,  0,  0, 4'h0, 4'h0, 4'h0};
        vecs[6]  = '{2'd1, 3'd0,  4,  0, 4'hF, 4'hF, 4'hF};
        vecs[7]  = '{2'd1, 3'd0,  4,  4, 4'h0, 4'h0, 4'h0};
        vecs[8]  = '{2'd1, 3'd0,  1,  5, 4'hF, 4'hF, 4'hF};
        vecs[9]  = '{2'd2, 3'd0,  0,  0, 4'h0, 4'h0, 4'h0};
        vecs[10] = '{2'd2, 3'd0, 13,  3, 4'h6, 4'h6, 4'h6};
        vecs[11] = '{2'd2, 3'd0, 31,  7, 4'hF, 4'hF, 4'hF};
        vecs[12] = '{2'd3, 3'd5, 10, 10, 4'hF, 4'h0, 4'hF};
        vecs[13] = '{2'd3, 3'd2,  2,  3, 4'h0, 4'hF, 4'h0};

        reset_n = 1'b0; pixel_enable = 1'b1; pattern_mode = 2'd0; solid_color = 3'd0;
        mh = 0; mv = 0; mmode = 2'd0; msolid = 3'd0; exp_now = reset_out();
        repeat (4) tick();
        check_val("rst_red", 32'(red), 0);
        check_val("rst_hs", 32'(horizontal_sync), 1);
        check_val("rst_vs", 32'(vertical_sync), 1);
        check_val("rst_de", 32'(display_enable), 0);
        check_val("rst_fs", 32'(frame_start), 0);
        check_val("rst_full_hs", 32'(f_hs), 1);
        check_val("rst_full_de", 32'(f_de), 0);

        // First line of the default-timing instance.
        reset_n = 1'b1;
        hs_first = -1; hs_last = -1; hs_cnt = 0; de_cnt = 0;
        for (int n = 0; n < 1344; n++) begin
            tick();
            if (!f_hs) begin
                if (hs_first < 0) hs_first = n;
                hs_last = n;
                hs_cnt++;
            end
            if (f_de) de_cnt++;
            if (n == 0)    check_val("full_fs_first", 32'(f_fs), 1);
            if (n == 127)  check_val("full_x127_rgb", 32'({f_red, f_green, f_blue}), 32'h0FFF);
            if (n == 128)  check_val("full_x128_rgb", 32'({f_red, f_green, f_blue}), 32'h0FF0);
            if (n == 1023) begin
                check_val("full_x1023_rgb", 32'({f_red, f_green, f_blue}), 32'h0000);
                check_val("full_x1023_px", 32'(f_px), 1023);
            end
        end
        check_val("full_hs_first", hs_first, 1048);
        check_val("full_hs_last", hs_last, 1183);
        check_val("full_hs_cnt", hs_cnt, 136);
        check_val("full_de_cnt", de_cnt, 1024);

        // One whole reduced frame from the origin.
        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            if (mh == 0 && mv == 0) begin hit = 1'b1; break; end
            tick();
        end
        check_val("frame_origin_reached", 32'(hit), 1);
        fs_cnt = 0; vs_first = -1; vs_last = -1; vs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (frame_start) fs_cnt++;
            if (!vertical_sync) begin
                if (vs_first < 0) vs_first = i / HT;
                vs_last = i / HT;
                vs_cnt++;
            end
        end
        check_val("frame_fs_cnt", fs_cnt, 1);
        check_val("frame_vs_first_line", vs_first, VV + VF);
        check_val("frame_vs_last_line", vs_last, VV + VF + VS - 1);
        check_val("frame_vs_cnt", vs_cnt, VS * HT);

        // Table of hand-derived pixels for each mode.
        foreach (vecs[i]) begin
            pattern_mode = vecs[i].mode;
            solid_color = vecs[i].solid;
            hit = 1'b0;
            for (int k = 0; k < 3 * FRAME; k++) begin
                tick();
                if (mmode == vecs[i].mode && (vecs[i].mode != 2'd3 || msolid == vecs[i].solid)
                    && exp_now.de && int'(exp_now.px) == vecs[i].x && int'(exp_now.py) == vecs[i].y) begin
                    hit = 1'b1;
                    break;
                end
            end
            check_val($sformatf("vec%0d_reached", i), 32'(hit), 1);
            check_val($sformatf("vec%0d_rgb", i), 32'({red, green, blue}),
                      32'({vecs[i].r, vecs[i].g, vecs[i].b}));
        end

        // Mode change mid-frame takes effect only at the next frame.
        pattern_mode = 2'd0; solid_color = 3'd0;
        hit = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            if (mmode == 2'd0 && mv == 12 && mh == 0) begin hit = 1'b1; break; end
        end
        check_val("chg_line12_reached", 32'(hit), 1);
        pattern_mode = 2'd3; solid_color = 3'b100;
        hit = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (exp_now.de && exp_now.px == 5'd4 && exp_now.py == 5'd20) begin hit = 1'b1; break; end
        end
        check_val("chg_late_px_reached", 32'(hit), 1);
        check_val("chg_still_bars", 32'({red, green, blue}), 32'h0FF0);
        hit = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
            tick();
            if (exp_now.fs) begin hit = 1'b1; break; end
        end
        check_val("chg_next_frame_reached", 32'(hit), 1);
        check_val("chg_next_frame_fs", 32'(frame_start), 1);
        check_val("chg_solid_red", 32'({red, green, blue}), 32'h0F00);

        // Strobe every other clock: one frame still spans FRAME enabled pixels.
        pattern_mode = 2'd1;
        prev_fs = frame_start; rises = 0; en_cnt = 0;
        for (int k = 0; k < 8 * FRAME && rises < 2; k++) begin
            pixel_enable = (k % 2 == 0);
            pe_edge = pixel_enable;
            tick();
            if (rises == 1 && pe_edge) en_cnt++;
            if (frame_start && !prev_fs) rises++;
            prev_fs = frame_start;
        end
        pixel_enable = 1'b1;
        check_val("toggle_rises", rises, 2);
        check_val("toggle_enabled_per_frame", en_cnt, FRAME);

        // Reset in the middle of a frame, release with the strobe low first.
        hit = 1'b0;
        for (int k = 0; k < 2 * FRAME; k++) begin
            tick();
            if (mv == 12) begin hit = 1'b1; break; end
        end
        check_val("rst_line12_reached", 32'(hit), 1);
        repeat (5) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        check_val("midrst_rgb", 32'({red, green, blue}), 0);
        check_val("midrst_hs", 32'(horizontal_sync), 1);
        check_val("midrst_vs", 32'(vertical_sync), 1);
        check_val("midrst_de", 32'(display_enable), 0);
        check_val("midrst_px", 32'(pixel_x), 0);
        check_val("midrst_py", 32'(pixel_y), 0);
        check_val("midrst_full_hs", 32'(f_hs), 1);
        reset_n = 1'b1;
        pixel_enable = 1'b0;
        repeat (3) tick();
        check_val("midrst_fs_idle", 32'(frame_start), 0);
        pixel_enable = 1'b1;
        tick();
        check_val("midrst_fs_pulse", 32'(frame_start), 1);
        check_val("midrst_de_first", 32'(display_enable), 1);
        check_val("midrst_px_first", 32'(pixel_x), 0);
        tick();
        check_val("midrst_fs_drop", 32'(frame_start), 0);
        check_val("midrst_px_second", 32'(pixel_x), 1);

        check_val("scoreboard_empty", 32'(sb_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
